// File: rtl/unisim_sram_b_1w1r_param.sv
// unisim_sram_b_1w1r_param
//   Parametrised 1W/1R SRAM built from a grid of 2048x8 block-RAM banks.
//   Adds a post-reset zero-fill engine, read-during-write forwarding with
//   mask merge, an optional output register and a read-valid strobe.
// Ports:
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   BUSY               clear in progress, both ports ignored while high
//   CE0 A0 D0 WE0 WEM0 write port (WEM0 bit = 1 writes that bit)
//   CE1 A1             read port
//   Q1 RVALID          read data and its one-cycle valid strobe

// Behavioural model of one BRAM_2048x8 macro: port 0 write-only with a
// per-bit mask, port 1 read-only, READ_FIRST, output holds when not read.
module unisim_sram_b_bank #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [7:0]    wm,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [7:0]    q
);
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= (mem[wa] & ~wm) | (wd & wm);
    if (re) q <= mem[ra];
  end
endmodule

module unisim_sram_b_1w1r_param #(
  parameter int ABITS = 12,
  parameter int DBITS = 16,
  parameter int OREG  = 0,
  parameter int CLEAR = 1
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             BUSY,
  input  logic             CE0,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic             WE0,
  input  logic [DBITS-1:0] WEM0,
  input  logic             CE1,
  input  logic [ABITS-1:0] A1,
  output logic [DBITS-1:0] Q1,
  output logic             RVALID
);
  localparam int LBITS  = (ABITS < 11) ? ABITS : 11;
  localparam int RBW    = (ABITS > LBITS) ? ABITS - LBITS : 1;
  localparam int NROW   = 1 << (ABITS - LBITS);
  localparam int NRA    = 1 << RBW;   // row slots addressable by RBW bits
  localparam int NCOL   = (DBITS + 7) / 8;
  localparam int DP     = NCOL * 8;
  localparam int STAGES = (OREG != 0) ? 2 : 1;

  typedef enum logic {IDLE, CLR} state_t;

  state_t           state, state_nx;
  logic [LBITS-1:0] cnt;
  logic             clr_we, wr_acc, rd_acc;

  // ---------------- clear FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) state <= (CLEAR != 0) ? CLR : IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == CLR && cnt == '1) state_nx = IDLE;
  end

  always_comb begin
    BUSY   = (CLEAR != 0) && (state == CLR);
    clr_we = BUSY && !RST;
  end

  always_ff @(posedge CLK) begin
    if (RST)         cnt <= '0;
    else if (clr_we) cnt <= cnt + 1'b1;
  end

  // Reset beats any same-cycle access.
  assign wr_acc = CE0 && WE0 && !BUSY && !RST;
  assign rd_acc = CE1 && !BUSY && !RST;

  // ---------------- bank grid ----------------
  logic [DP-1:0]          dpad, mpad;
  logic [RBW-1:0]         wrow, rrow, rsel;
  logic [LBITS-1:0]       bwa;
  logic [7:0]             bwd [NCOL];
  logic [7:0]             bwm [NCOL];
  logic [NRA-1:0]         row_we, row_re;
  logic [NRA-1:0][DP-1:0] bq;

  // Zero padding keeps the unused top-column mask bits at 0.
  assign dpad = DP'(D0);
  assign mpad = DP'(WEM0);
  assign bwa  = clr_we ? cnt : A0[LBITS-1:0];

  generate
    if (ABITS > LBITS) begin : g_rows
      assign wrow = A0[ABITS-1:LBITS];
      assign rrow = A1[ABITS-1:LBITS];
    end else begin : g_norow
      assign wrow = '0;
      assign rrow = '0;
    end

    for (genvar c = 0; c < NCOL; c++) begin : g_colsig
      assign bwd[c] = clr_we ? 8'h00 : dpad[8*c +: 8];
      assign bwm[c] = clr_we ? 8'hFF : mpad[8*c +: 8];
    end

    for (genvar r = 0; r < NRA; r++) begin : g_row
      if (r < NROW) begin : g_live
        // The clear engine writes every row at once.
        assign row_we[r] = clr_we || (wr_acc && wrow == RBW'(r));
        assign row_re[r] = rd_acc && rrow == RBW'(r);
        for (genvar c = 0; c < NCOL; c++) begin : g_col
          unisim_sram_b_bank #(.AW(LBITS)) u_bank (
            .clk (CLK),
            .we  (row_we[r]),
            .wa  (bwa),
            .wd  (bwd[c]),
            .wm  (bwm[c]),
            .re  (row_re[r]),
            .ra  (A1[LBITS-1:0]),
            .q   (bq[r][8*c +: 8])
          );
        end
      end else begin : g_dead
        assign row_we[r] = 1'b0;
        assign row_re[r] = 1'b0;
        assign bq[r]     = '0;
      end
    end
  endgenerate

  // ---------------- read side ----------------
  logic          fwd, has;
  logic [DP-1:0] fd, fm, rdata;
  logic [STAGES:1] vld_pipe;

  // Row select, forward state and "has data" only move on an accepted read,
  // so the combinational read data is stable between reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsel <= '0;
      fwd  <= 1'b0;
      fd   <= '0;
      fm   <= '0;
      has  <= 1'b0;
    end else if (rd_acc) begin
      rsel <= rrow;
      fwd  <= wr_acc && (A0 == A1);
      fd   <= dpad;
      fm   <= mpad;
      has  <= 1'b1;
    end
  end

  // READ_FIRST bank returns old data on a collision; merge in the new bits.
  always_comb begin
    rdata = '0;
    if (has) rdata = fwd ? ((fd & fm) | (bq[rsel] & ~fm)) : bq[rsel];
  end

  always_ff @(posedge CLK) begin
    if (RST) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_acc;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign RVALID = vld_pipe[STAGES];

  generate
    if (OREG != 0) begin : g_oreg
      logic [DP-1:0] q_r;
      always_ff @(posedge CLK) begin
        if (RST)              q_r <= '0;
        else if (vld_pipe[1]) q_r <= rdata;
      end
      assign Q1 = q_r[DBITS-1:0];
    end else begin : g_noreg
      assign Q1 = rdata[DBITS-1:0];
    end
  endgenerate
endmodule
